// File: rtl/sdram_line_scheduler.sv
// sdram_line_scheduler: shares SDRAM port 0 between download writes and per-line burst prefetch.
// Define LINE_SCHED_STATS_EN to build the saturating line/underrun counters.
module sdram_line_scheduler #(
    parameter int WORDS_PER_LINE = 2160,
    parameter int LINE_STRIDE    = 2160,
    parameter int LINES          = 720,
    parameter int END_EARLY      = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        line_start,
    input  logic [9:0]  line_index,
    input  logic        wr_req,
    input  logic [24:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    output logic [24:0] sd_addr,
    output logic [15:0] sd_data,
    output logic        sd_wr_req,
    output logic        sd_rd_req,
    output logic        sd_end_burst_req,
    input  logic        sd_data_available,
    input  logic [15:0] sd_q,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] stat_lines,
    output logic [15:0] stat_underruns
);
    typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, BURST, DRAIN} state_t;
    localparam logic [15:0] WPL    = 16'(WORDS_PER_LINE);
    localparam logic [15:0] END_AT = 16'(WORDS_PER_LINE - END_EARLY - 1);
    state_t      state, state_n;
    logic [15:0] count, count_n, data_n, pix_data_n;
    logic [24:0] base, base_n, new_base, addr_n;
    logic        end_sent, end_sent_n, prev_avail, fall;
    logic        wr_ack_n, wr_req_n, rd_req_n, end_n, pix_valid_n, underrun_n;

    assign fall     = prev_avail & ~sd_data_available;
    assign new_base = ({22'd0, line_index} >= LINES) ? '0 : 25'(line_index) * 25'(LINE_STRIDE);

    always_comb begin
        state_n     = state;
        count_n     = count;
        base_n      = base;
        end_sent_n  = end_sent;
        addr_n      = sd_addr;
        data_n      = sd_data;
        pix_data_n  = pix_data;
        wr_ack_n    = 1'b0;
        wr_req_n    = 1'b0;
        rd_req_n    = 1'b0;
        end_n       = 1'b0;
        pix_valid_n = 1'b0;
        underrun_n  = 1'b0;
        case (state)
            IDLE, WRITE: begin
                // a write is issued straight from IDLE so the ack is seen before wr_req is re-sampled
                if (line_start) begin
                    base_n     = new_base;
                    count_n    = '0;
                    end_sent_n = 1'b0;
                    state_n    = RD_REQ;
                end else if (wr_req && state == IDLE) begin
                    wr_ack_n = 1'b1;
                    wr_req_n = 1'b1;
                    addr_n   = wr_addr;
                    data_n   = wr_data;
                    state_n  = WRITE;
                end else begin
                    state_n = IDLE;
                end
            end
            RD_REQ: begin
                if (line_start) begin
                    underrun_n = 1'b1;
                    base_n     = new_base;
                    count_n    = '0;
                end else begin
                    rd_req_n = 1'b1;
                    addr_n   = base + 25'(count);
                    state_n  = BURST;
                end
            end
            BURST: begin
                if (line_start) begin
                    // if the burst ends this very cycle there is nothing left to drain
                    underrun_n = 1'b1;
                    base_n     = new_base;
                    end_n      = !end_sent && !fall;
                    count_n    = '0;
                    end_sent_n = 1'b0;
                    state_n    = fall ? RD_REQ : DRAIN;
                end else if (fall) begin
                    state_n = (count < WPL) ? RD_REQ : IDLE;
                end else if (sd_data_available) begin
                    pix_valid_n = count < WPL;
                    pix_data_n  = (count < WPL) ? sd_q : pix_data;
                    count_n     = (count < WPL) ? count + 16'd1 : count;
                    end_n       = !end_sent && count >= END_AT;
                    end_sent_n  = end_sent || count >= END_AT;
                end
            end
            DRAIN: begin
                underrun_n = line_start;
                base_n     = line_start ? new_base : base;
                if (fall) begin
                    count_n    = '0;
                    end_sent_n = 1'b0;
                    state_n    = RD_REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            count            <= '0;
            base             <= '0;
            end_sent         <= 1'b0;
            prev_avail       <= 1'b0;
            wr_ack           <= 1'b0;
            sd_addr          <= '0;
            sd_data          <= '0;
            sd_wr_req        <= 1'b0;
            sd_rd_req        <= 1'b0;
            sd_end_burst_req <= 1'b0;
            pix_valid        <= 1'b0;
            pix_data         <= '0;
            busy             <= 1'b0;
            underrun         <= 1'b0;
        end else begin
            state            <= state_n;
            count            <= count_n;
            base             <= base_n;
            end_sent         <= end_sent_n;
            prev_avail       <= sd_data_available;
            wr_ack           <= wr_ack_n;
            sd_addr          <= addr_n;
            sd_data          <= data_n;
            sd_wr_req        <= wr_req_n;
            sd_rd_req        <= rd_req_n;
            sd_end_burst_req <= end_n;
            pix_valid        <= pix_valid_n;
            pix_data         <= pix_data_n;
            busy             <= state_n != IDLE;
            underrun         <= underrun_n;
        end
    end

`ifdef LINE_SCHED_STATS_EN
    logic done;
    assign done = state == BURST && !line_start && fall && count >= WPL;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_lines     <= '0;
            stat_underruns <= '0;
        end else begin
            if (done && stat_lines != 16'hFFFF) stat_lines <= stat_lines + 16'd1;
            if (underrun_n && stat_underruns != 16'hFFFF) stat_underruns <= stat_underruns + 16'd1;
        end
    end
`else
    assign stat_lines     = '0;
    assign stat_underruns = '0;
`endif
endmodule
